// File: rtl/id_ex_pipe.sv
// Decode->execute pipeline register: operand muxing, immediate extension,
// stall/flush control, valid tracking, memory-access tagging and stall monitoring.
module id_ex_pipe #(
    parameter int unsigned W       = 16,
    parameter int unsigned CTRL_W  = 8,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned ACT_W   = 2,
    parameter int unsigned STALL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                mem_access,
    input  logic [W-1:0]        pc,
    input  logic [W-1:0]        src1,
    input  logic [W-1:0]        src2,
    input  logic [W-1:0]        imm_raw,
    input  logic [LEN_W-1:0]    imm_len,
    input  logic                imm_sign,
    input  logic [1:0]          op1_sel,
    input  logic [1:0]          op2_sel,
    input  logic [CTRL_W-1:0]   ctrl_in,
    output logic                out_valid,
    output logic [W-1:0]        pc_out,
    output logic [W-1:0]        op1,
    output logic [W-1:0]        op2,
    output logic [W-1:0]        store_val,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic [ACT_W-1:0]    mem_tag,
    output logic                mem_trig,
    output logic [STALL_W-1:0]  stall_cnt
);

    localparam logic [LEN_W-1:0]   LEN_FULL  = LEN_W'(W);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    logic [W-1:0] imm_mask;
    logic [W-1:0] imm_shr;
    logic         imm_ext_bit;
    logic [W-1:0] imm_ext;
    logic [W-1:0] op1_nxt;
    logic [W-1:0] op2_nxt;

    // Immediate extension: keep the low imm_len bits, fill the rest with the sign if requested
    always_comb begin
        imm_mask    = ~({W{1'b1}} << imm_len);
        imm_shr     = imm_raw >> (imm_len - LEN_W'(1));
        imm_ext_bit = imm_sign & imm_shr[0];
        imm_ext     = '0;
        if (imm_len >= LEN_FULL) begin
            imm_ext = imm_raw;
        end else if (imm_len != '0) begin
            imm_ext = (imm_raw & imm_mask) | ({W{imm_ext_bit}} & ~imm_mask);
        end
    end

    // Operand selection
    always_comb begin
        op1_nxt = '0;
        case (op1_sel)
            2'd0:    op1_nxt = src1;
            2'd1:    op1_nxt = src2;
            2'd2:    op1_nxt = pc + W'(1);
            default: op1_nxt = '0;
        endcase
        op2_nxt = '0;
        case (op2_sel)
            2'd0:    op2_nxt = src2;
            2'd1:    op2_nxt = imm_ext;
            2'd2:    op2_nxt = '0;
            default: op2_nxt = src1;
        endcase
    end

    // Stage register: reset > flush > hold > load
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            pc_out    <= '0;
            op1       <= '0;
            op2       <= '0;
            store_val <= '0;
            ctrl_out  <= '0;
            mem_tag   <= '0;
            mem_trig  <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            store_val <= '0;
            ctrl_out  <= '0;
            mem_trig  <= 1'b0;
            stall_cnt <= '0;
        end else if (hold) begin
            mem_trig <= 1'b0;
            if (!out_valid) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end else begin
            out_valid <= in_valid;
            pc_out    <= pc;
            op1       <= op1_nxt;
            op2       <= op2_nxt;
            store_val <= src2;
            ctrl_out  <= in_valid ? ctrl_in : '0;
            stall_cnt <= '0;
            mem_trig  <= in_valid & mem_access;
            if (in_valid && mem_access) begin
                mem_tag <= mem_tag + ACT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe with default parameters.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        in_valid;
    logic        mem_access;
    logic [15:0] pc;
    logic [15:0] src1;
    logic [15:0] src2;
    logic [15:0] imm_raw;
    logic [4:0]  imm_len;
    logic        imm_sign;
    logic [1:0]  op1_sel;
    logic [1:0]  op2_sel;
    logic [7:0]  ctrl_in;
    logic        out_valid;
    logic [15:0] pc_out;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] store_val;
    logic [7:0]  ctrl_out;
    logic [1:0]  mem_tag;
    logic        mem_trig;
    logic [3:0]  stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    id_ex_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .flush      (flush),
        .in_valid   (in_valid),
        .mem_access (mem_access),
        .pc         (pc),
        .src1       (src1),
        .src2       (src2),
        .imm_raw    (imm_raw),
        .imm_len    (imm_len),
        .imm_sign   (imm_sign),
        .op1_sel    (op1_sel),
        .op2_sel    (op2_sel),
        .ctrl_in    (ctrl_in),
        .out_valid  (out_valid),
        .pc_out     (pc_out),
        .op1        (op1),
        .op2        (op2),
        .store_val  (store_val),
        .ctrl_out   (ctrl_out),
        .mem_tag    (mem_tag),
        .mem_trig   (mem_trig),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; flush = 1'b0; in_valid = 1'b0; mem_access = 1'b0;
        pc = 16'h0; src1 = 16'h0; src2 = 16'h0; imm_raw = 16'h0; imm_len = 5'd0;
        imm_sign = 1'b0; op1_sel = 2'd0; op2_sel = 2'd0; ctrl_in = 8'h0;
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_op1",   32'(op1),       32'h0);
        chk("rst_tag",   32'(mem_tag),   32'h0);
        chk("rst_stall", 32'(stall_cnt), 32'h0);

        // Sign / zero extension of an 8-bit immediate
        rst = 1'b1; in_valid = 1'b1; pc = 16'h0010; src1 = 16'h1234; src2 = 16'h5678;
        imm_raw = 16'h00F5; imm_len = 5'd8; imm_sign = 1'b1; op2_sel = 2'd1; ctrl_in = 8'h5A;
        step();
        chk("sext8_op2",   32'(op2),       32'hFFF5);
        chk("sext8_op1",   32'(op1),       32'h1234);
        chk("sext8_store", 32'(store_val), 32'h5678);
        chk("sext8_pc",    32'(pc_out),    32'h0010);
        chk("sext8_ctrl",  32'(ctrl_out),  32'h5A);
        chk("sext8_valid", 32'(out_valid), 32'h1);
        chk("sext8_trig",  32'(mem_trig),  32'h0);
        imm_sign = 1'b0;
        step();
        chk("zext8_op2", 32'(op2), 32'h00F5);

        // Upper raw bits ignored; length boundaries; pc+1 wrap
        imm_raw = 16'hFFFF; imm_len = 5'd4; pc = 16'hFFFF; op1_sel = 2'd2;
        step();
        chk("zext4_op2",   32'(op2), 32'h000F);
        chk("pc_wrap_op1", 32'(op1), 32'h0000);
        imm_len = 5'd0; pc = 16'h0041;
        step();
        chk("len0_op2", 32'(op2), 32'h0000);
        chk("pc1_op1",  32'(op1), 32'h0042);
        imm_raw = 16'h8001; imm_len = 5'd16; imm_sign = 1'b1;
        step();
        chk("len16_op2", 32'(op2), 32'h8001);
        imm_raw = 16'h3008; imm_len = 5'd4; op1_sel = 2'd1;
        step();
        chk("sext4_op2", 32'(op2), 32'hFFF8);
        chk("sel1_op1",  32'(op1), 32'h5678);
        op1_sel = 2'd3; op2_sel = 2'd3;
        step();
        chk("sel3_op1", 32'(op1), 32'h0000);
        chk("sel3_op2", 32'(op2), 32'h1234);
        op1_sel = 2'd0; op2_sel = 2'd2;
        step();
        chk("sel2_op2", 32'(op2), 32'h0000);
        op2_sel = 2'd0;
        step();
        chk("sel0_op2", 32'(op2), 32'h5678);

        // Back-to-back memory accesses: tag wraps 1,2,3,0
        mem_access = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("tag_%0d", i), 32'(mem_tag), 32'(i % 4));
            chk($sformatf("trig_%0d", i), 32'(mem_trig), 32'h1);
        end
        mem_access = 1'b0;
        step();
        chk("nomem_trig", 32'(mem_trig), 32'h0);
        chk("nomem_tag",  32'(mem_tag),  32'h0);

        // Load, then hold 20 cycles with changing inputs
        mem_access = 1'b1; pc = 16'h0200; src1 = 16'hAAAA; src2 = 16'h5555; ctrl_in = 8'hC3;
        step();
        chk("preh_tag", 32'(mem_tag), 32'h1);
        hold = 1'b1; mem_access = 1'b0; pc = 16'h0999; src1 = 16'h1111; src2 = 16'h2222;
        ctrl_in = 8'h11;
        step();
        chk("hold1_trig",  32'(mem_trig),  32'h0);
        chk("hold1_stall", 32'(stall_cnt), 32'h1);
        for (int i = 2; i <= 20; i++) step();
        chk("hold20_stall", 32'(stall_cnt), 32'hF);
        chk("hold20_op1",   32'(op1),       32'hAAAA);
        chk("hold20_pc",    32'(pc_out),    32'h0200);
        chk("hold20_ctrl",  32'(ctrl_out),  32'hC3);
        chk("hold20_valid", 32'(out_valid), 32'h1);
        chk("hold20_tag",   32'(mem_tag),   32'h1);
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_ctrl",  32'(ctrl_out),  32'h0);
        chk("flush_stall", 32'(stall_cnt), 32'h0);
        chk("flush_op1",   32'(op1),       32'h0);
        chk("flush_store", 32'(store_val), 32'h0);
        chk("flush_pc",    32'(pc_out),    32'h0200);
        chk("flush_tag",   32'(mem_tag),   32'h1);
        flush = 1'b0;
        step();
        chk("hold_inv_stall", 32'(stall_cnt), 32'h0);

        // Bubble: control forced to zero, no tag advance
        hold = 1'b0; in_valid = 1'b0; ctrl_in = 8'hFF; mem_access = 1'b1;
        step();
        chk("bub_valid", 32'(out_valid), 32'h0);
        chk("bub_ctrl",  32'(ctrl_out),  32'h0);
        chk("bub_trig",  32'(mem_trig),  32'h0);
        chk("bub_tag",   32'(mem_tag),   32'h1);

        // Reset during hold clears everything
        in_valid = 1'b1;
        step();
        chk("pre_rst_tag", 32'(mem_tag), 32'h2);
        hold = 1'b1; mem_access = 1'b0;
        step();
        rst = 1'b0;
        step();
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_tag",   32'(mem_tag),   32'h0);
        chk("mrst_pc",    32'(pc_out),    32'h0);
        chk("mrst_ctrl",  32'(ctrl_out),  32'h0);
        chk("mrst_stall", 32'(stall_cnt), 32'h0);
        chk("mrst_op2",   32'(op2),       32'h0);
        rst = 1'b1; hold = 1'b0; mem_access = 1'b1; pc = 16'h0300; ctrl_in = 8'h21;
        step();
        chk("resume_valid", 32'(out_valid), 32'h1);
        chk("resume_pc",    32'(pc_out),    32'h0300);
        chk("resume_ctrl",  32'(ctrl_out),  32'h21);
        chk("resume_tag",   32'(mem_tag),   32'h1);
        chk("resume_trig",  32'(mem_trig),  32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
